tl_ul_mem_responder: RTL and testbench
======================================

# tl_ul_mem_responder

TileLink UltraLite responder that terminates the A channel in a small byte-masked register memory and returns D-channel responses. It sits on the slave side of the TL-UL link, in place of or alongside `tilelink_ul_slave_top`, and serves master traffic for loopback and integration tests. It holds one outstanding response, accepts a new request in the cycle its response is consumed, and returns error responses for out-of-range, misaligned or unsupported requests.

## Interface
- TL_ADDR_WIDTH, 64: A-channel address width.
- TL_DATA_WIDTH, 64: beat width in bits.
- TL_STRB_WIDTH, TL_DATA_WIDTH/8: mask width in bytes.
- TL_SOURCE_WIDTH, 3: source ID width.
- TL_SINK_WIDTH, 3: sink ID width.
- TL_OPCODE_WIDTH, 3: opcode width.
- TL_PARAM_WIDTH, 3: param width.
- TL_SIZE_WIDTH, 8: size field width, log2 of the byte count.
- MEM_DEPTH, 16: number of beat-wide words.
- BASE_ADDR, 0: byte address of word 0.
- SINK_ID, 0: value driven on d_sink.

Ports:
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  request valid.
- a_ready  out  1  request accepted.
- a_opcode  in  TL_OPCODE_WIDTH  request opcode.
- a_param  in  TL_PARAM_WIDTH  request param; ignored.
- a_address  in  TL_ADDR_WIDTH  byte address.
- a_size  in  TL_SIZE_WIDTH  log2 of the byte count.
- a_mask  in  TL_STRB_WIDTH  byte lane enables.
- a_data  in  TL_DATA_WIDTH  write data.
- a_source  in  TL_SOURCE_WIDTH  requester ID.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted.
- d_opcode  out  TL_OPCODE_WIDTH  response opcode.
- d_param  out  TL_PARAM_WIDTH  response param; always 0.
- d_size  out  TL_SIZE_WIDTH  echo of a_size.
- d_sink  out  TL_SINK_WIDTH  equals SINK_ID.
- d_source  out  TL_SOURCE_WIDTH  echo of a_source.
- d_data  out  TL_DATA_WIDTH  read data.
- d_error  out  1  denied or corrupt response.

## Operation
- **State machine:** two states, IDLE (no response held) and RESPONSE (D outputs valid).
  - IDLE → RESPONSE on A fire.
  - RESPONSE → IDLE on D fire with no A fire in the same cycle.
  - RESPONSE → RESPONSE on simultaneous D fire and A fire; the new response overwrites the D registers.
- **Ready:** a_ready = !d_valid || d_ready (bypass). A fire is a_valid && a_ready.
- **Word index:** (a_address − BASE_ADDR) >> log2(TL_STRB_WIDTH).
- **Error conditions.** Any one of the following sets d_error=1:
  - a_address < BASE_ADDR;
  - word index ≥ MEM_DEPTH;
  - a_size > log2(TL_STRB_WIDTH);
  - a_address not aligned to 2^a_size.
- **GET:** d_opcode=ACCESS_ACK_DATA. d_data = memory word, full beat; a_mask does not affect reads. On error, d_data=0.
- **PUT_FULL_DATA / PUT_PARTIAL_DATA:** each byte lane with a_mask bit set takes the corresponding a_data byte. d_opcode=ACCESS_ACK, d_data=0.
  - The memory write occurs on the A-fire clock edge, and only when d_error=0.
- **ARITHMETIC_DATA / LOGICAL_DATA:** ACCESS_ACK_DATA, d_error=1, d_data=0, no write.
- **INTENT:** HINT_ACK, d_error=0, no effect.
- **ACQUIRE_BLOCK / ACQUIRE_PERM:** ACCESS_ACK, d_error=1.
- **Held outputs:** while d_valid=1 and d_ready=0, all D outputs are held stable.

## Timing
- Latency: A fire on edge N gives d_valid=1 with its response on edge N+1.
- Sustained throughput is one request per cycle when d_ready stays 1.
- Read-after-write: a PUT at edge N followed by a GET at edge N+1 returns the new data.
- Reset values:
  - d_valid=0;
  - d_opcode, d_param, d_size, d_source, d_data and d_error all 0;
  - d_sink=SINK_ID;
  - state IDLE;
  - all memory words 0.
- a_ready is 1 from the first edge after reset release.
- Reset asserted mid-response: d_valid drops to 0 asynchronously, the pending response is discarded, and memory is cleared.
- d_ready asserted while d_valid=0 has no effect.

## Structure
- Package tl_ul_pkg holds:
  - the A opcodes (PUT_FULL_DATA_A … ACQUIRE_PERM_A, values 0–7);
  - the D opcodes (ACCESS_ACK_D=0, ACCESS_ACK_DATA_D=1, HINT_ACK_D=2, GRANT_D=4, GRANT_DATA_D=5, RELEASE_ACK_D=6);
  - the state encodings IDLE and RESPONSE;
  - the default width constants.
- One sub-module, tl_ul_mem_array: a MEM_DEPTH × TL_DATA_WIDTH flop array with byte-masked write, combinational read, and asynchronous clear.

## Test plan
- **Write then read:** reset, then PutFull addr 0x8, size 3, mask 0xFF, data 0x1122334455667788, source 2 → AccessAck with d_source=2, d_error=0. Then Get addr 0x8 → AccessAckData with d_data=0x1122334455667788.
- **Partial write:** PutPartial addr 0x8, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB → a following Get returns 0x11223344_BBBBBBBB.
- **Errors:**
  - Get addr 0x80 (index 16) → d_error=1, d_data=0.
  - Get addr 0x4 with size 3 (misaligned) → d_error=1.
  - A following Get addr 0x0 still returns 0.
- **Backpressure:** hold d_ready=0 for 5 cycles after a Get → d_valid and all D outputs stable, a_ready=0. Release d_ready → a queued request is accepted in the same cycle.
- **Streaming:** 8 back-to-back Puts then 8 Gets with d_ready=1 → one response per cycle and d_source echo correct for each.
- **Reset mid-response:** assert rst=0 with d_valid=1 → d_valid=0 immediately. After release, Get addr 0x8 returns 0.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcodes, responder state encoding and default widths.
package tl_ul_pkg;

  localparam int DEF_ADDR_WIDTH   = 64;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_SOURCE_WIDTH = 3;
  localparam int DEF_SINK_WIDTH   = 3;
  localparam int DEF_OPCODE_WIDTH = 3;
  localparam int DEF_PARAM_WIDTH  = 3;
  localparam int DEF_SIZE_WIDTH   = 8;
  localparam int DEF_MEM_DEPTH    = 16;

  typedef enum logic [2:0] {
    PUT_FULL_DATA_A    = 3'd0,
    PUT_PARTIAL_DATA_A = 3'd1,
    ARITHMETIC_DATA_A  = 3'd2,
    LOGICAL_DATA_A     = 3'd3,
    GET_A              = 3'd4,
    INTENT_A           = 3'd5,
    ACQUIRE_BLOCK_A    = 3'd6,
    ACQUIRE_PERM_A     = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK_D      = 3'd0,
    ACCESS_ACK_DATA_D = 3'd1,
    HINT_ACK_D        = 3'd2,
    GRANT_D           = 3'd4,
    GRANT_DATA_D      = 3'd5,
    RELEASE_ACK_D     = 3'd6
  } tl_d_op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    RESPONSE = 1'b1
  } tl_state_e;

endpackage

// File: rtl/tl_ul_mem_array.sv
// Word-addressed flop memory: byte-masked write, combinational read,
// asynchronous clear of every word.
module tl_ul_mem_array #(
  parameter int MEM_DEPTH = 16,
  parameter int DATA_W    = 64,
  parameter int IDX_W     = 4,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [MEM_DEPTH-1:0][DATA_W-1:0] mem;

  // Byte lanes of the addressed word update only where the mask is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (we) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        if (waddr == IDX_W'(w)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wmask[b]) mem[w][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tl_ul_mem_responder.sv
// TL-UL responder: terminates the A channel in a small register memory and
// returns one registered D response per accepted request.
module tl_ul_mem_responder
  import tl_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int TL_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = DEF_SOURCE_WIDTH,
  parameter int TL_SINK_WIDTH   = DEF_SINK_WIDTH,
  parameter int TL_OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int TL_PARAM_WIDTH  = DEF_PARAM_WIDTH,
  parameter int TL_SIZE_WIDTH   = DEF_SIZE_WIDTH,
  parameter int MEM_DEPTH       = DEF_MEM_DEPTH,
  parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [TL_SINK_WIDTH-1:0] SINK_ID   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
);

  localparam int LOG2_STRB = $clog2(TL_STRB_WIDTH);
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef struct packed {
    logic [TL_OPCODE_WIDTH-1:0] opcode;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [TL_DATA_WIDTH-1:0]   data;
    logic                       error;
  } rsp_t;

  tl_state_e                state_q, state_d;
  rsp_t                     rsp_q, rsp_d;
  logic                     a_fire, d_fire;
  logic [TL_ADDR_WIDTH-1:0] offset, word_idx;
  logic                     below_base, out_range, size_big, misalign, range_err;
  logic                     mem_we;
  logic [TL_DATA_WIDTH-1:0] rdata;
  logic                     unused_param;

  // a_param carries no meaning for this target.
  assign unused_param = ^a_param;

  assign d_valid = (state_q == RESPONSE);
  assign a_ready = !d_valid || d_ready;
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;

  assign offset     = a_address - BASE_ADDR;
  assign word_idx   = offset >> LOG2_STRB;
  assign below_base = a_address < BASE_ADDR;
  assign out_range  = word_idx >= TL_ADDR_WIDTH'(MEM_DEPTH);
  assign size_big   = a_size > TL_SIZE_WIDTH'(LOG2_STRB);

  // Address must be aligned to 2^a_size; oversized requests are rejected
  // by size_big, so only the in-beat low bits need checking.
  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < LOG2_STRB; i++) begin
      if (a_address[i] && (TL_SIZE_WIDTH'(i) < a_size)) misalign = 1'b1;
    end
  end

  assign range_err = below_base || out_range || size_big || misalign;

  // Decode the incoming request into the response it will produce.
  always_comb begin
    rsp_d        = '0;
    rsp_d.size   = a_size;
    rsp_d.source = a_source;
    rsp_d.opcode = TL_OPCODE_WIDTH'(ACCESS_ACK_D);
    mem_we       = 1'b0;
    case (a_opcode)
      GET_A: begin
        rsp_d.opcode = TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D);
        rsp_d.error  = range_err;
        rsp_d.data   = range_err ? '0 : rdata;
      end
      PUT_FULL_DATA_A, PUT_PARTIAL_DATA_A: begin
        rsp_d.error = range_err;
        mem_we      = a_fire && !range_err;
      end
      ARITHMETIC_DATA_A, LOGICAL_DATA_A: begin
        rsp_d.opcode = TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D);
        rsp_d.error  = 1'b1;
      end
      INTENT_A: begin
        rsp_d.opcode = TL_OPCODE_WIDTH'(HINT_ACK_D);
      end
      ACQUIRE_BLOCK_A, ACQUIRE_PERM_A: begin
        rsp_d.error = 1'b1;
      end
      default: begin
        rsp_d.error = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A response is held until consumed; a same-cycle accept keeps us busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (a_fire) state_d = RESPONSE;
      RESPONSE: if (d_fire && !a_fire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // D registers load only on accept, so they are stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rsp_q <= '0;
    else if (a_fire) rsp_q <= rsp_d;
  end

  assign d_opcode = rsp_q.opcode;
  assign d_param  = '0;
  assign d_size   = rsp_q.size;
  assign d_sink   = SINK_ID;
  assign d_source = rsp_q.source;
  assign d_data   = rsp_q.data;
  assign d_error  = rsp_q.error;

  tl_ul_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (TL_DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (word_idx[IDX_W-1:0]),
    .wmask (a_mask),
    .wdata (a_data),
    .raddr (word_idx[IDX_W-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Bench for tl_ul_mem_responder: vector table plus backpressure, streaming
// and reset corner sequences, checked through an expected-response queue.
module tb_tl_ul_mem_responder;
  import tl_ul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, a_ready, d_valid, d_ready, d_error;
  logic [2:0]  a_opcode, a_param, a_source, d_opcode, d_param, d_sink, d_source;
  logic [63:0] a_address, a_data, d_data;
  logic [7:0]  a_size, a_mask, d_size;

  tl_ul_mem_responder dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink), .d_source(d_source), .d_data(d_data),
    .d_error(d_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] data;
    logic        err;
    logic [2:0]  src;
    logic [7:0]  size;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  size;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  eop;
    logic [63:0] edata;
    logic        eerr;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [63:0] addr,
                              input logic [7:0] size, input logic [7:0] mask,
                              input logic [63:0] data, input logic [2:0] eop,
                              input logic [63:0] edata, input logic eerr);
    vec_t v;
    v.op = op; v.addr = addr; v.size = size; v.mask = mask; v.data = data;
    v.eop = eop; v.edata = edata; v.eerr = eerr;
    return v;
  endfunction

  function automatic exp_t mkexp(input logic [2:0] op, input logic [63:0] data,
                                 input logic err, input logic [2:0] src,
                                 input logic [7:0] size);
    exp_t e;
    e.op = op; e.data = data; e.err = err; e.src = src; e.size = size;
    return e;
  endfunction

  function automatic logic [63:0] sdata(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i * 3)};
  endfunction

  // Scoreboard: every consumed response is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && d_valid && d_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got response src %0d expected none", d_source);
      end else begin
        e = sb.pop_front();
        chk("rsp_opcode", 64'(d_opcode), 64'(e.op));
        chk("rsp_data",   d_data,        e.data);
        chk("rsp_error",  64'(d_error),  64'(e.err));
        chk("rsp_source", 64'(d_source), 64'(e.src));
        chk("rsp_size",   64'(d_size),   64'(e.size));
        chk("rsp_param",  64'(d_param),  64'd0);
        chk("rsp_sink",   64'(d_sink),   64'd0);
      end
    end
  end

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                      input logic [7:0] mask, input logic [63:0] data, input logic [2:0] src,
                      input exp_t e, output int waits);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_size = size;
    a_mask = mask; a_data = data; a_source = src; a_param = 3'($urandom);
    sb.push_back(e);
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (a_ready) begin
        @(posedge clk); #1;
        break;
      end
      waits++;
      if (waits > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no a_ready expected accept within 50 cycles");
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  vec_t vt[26];

  initial begin
    int w;
    a_valid = 0; a_opcode = 0; a_param = 0; a_address = 0; a_size = 0;
    a_mask = 0; a_data = 0; a_source = 0; d_ready = 1'b1;

    vt[0]  = mk(PUT_FULL_DATA_A,    64'h8,  3, 8'hFF, 64'h1122334455667788, ACCESS_ACK_D,      64'h0, 0);
    vt[1]  = mk(GET_A,              64'h8,  3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h1122334455667788, 0);
    vt[2]  = mk(PUT_PARTIAL_DATA_A, 64'h8,  3, 8'h0F, 64'hAAAAAAAABBBBBBBB, ACCESS_ACK_D,      64'h0, 0);
    vt[3]  = mk(GET_A,              64'h8,  3, 8'h00, 64'h0,                ACCESS_ACK_DATA_D, 64'h11223344BBBBBBBB, 0);
    vt[4]  = mk(GET_A,              64'h80, 3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 1);
    vt[5]  = mk(GET_A,              64'h4,  3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 1);
    vt[6]  = mk(GET_A,              64'h0,  3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 0);
    vt[7]  = mk(PUT_FULL_DATA_A,    64'h80, 3, 8'hFF, 64'hFFFFFFFFFFFFFFFF, ACCESS_ACK_D,      64'h0, 1);
    vt[8]  = mk(GET_A,              64'h78, 3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 0);
    vt[9]  = mk(PUT_PARTIAL_DATA_A, 64'h78, 3, 8'h80, 64'hCCDDEEFF11223344, ACCESS_ACK_D,      64'h0, 0);
    vt[10] = mk(GET_A,              64'h7C, 2, 8'hF0, 64'h0,                ACCESS_ACK_DATA_D, 64'hCC00000000000000, 0);
    vt[11] = mk(GET_A,              64'h0,  4, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 1);
    vt[12] = mk(GET_A,              64'h9,  0, 8'h02, 64'h0,                ACCESS_ACK_DATA_D, 64'h11223344BBBBBBBB, 0);
    vt[13] = mk(PUT_FULL_DATA_A,    64'h12, 2, 8'hFF, 64'hFFFFFFFFFFFFFFFF, ACCESS_ACK_D,      64'h0, 1);
    vt[14] = mk(GET_A,              64'h10, 3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 0);
    vt[15] = mk(ARITHMETIC_DATA_A,  64'h0,  3, 8'hFF, 64'h5555,             ACCESS_ACK_DATA_D, 64'h0, 1);
    vt[16] = mk(LOGICAL_DATA_A,     64'h8,  3, 8'hFF, 64'h6666,             ACCESS_ACK_DATA_D, 64'h0, 1);
    vt[17] = mk(INTENT_A,           64'h0,  3, 8'hFF, 64'h0,                HINT_ACK_D,        64'h0, 0);
    vt[18] = mk(ACQUIRE_BLOCK_A,    64'h0,  3, 8'hFF, 64'h0,                ACCESS_ACK_D,      64'h0, 1);
    vt[19] = mk(ACQUIRE_PERM_A,     64'h0,  3, 8'hFF, 64'h0,                ACCESS_ACK_D,      64'h0, 1);
    vt[20] = mk(GET_A,              64'h8,  3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h11223344BBBBBBBB, 0);
    vt[21] = mk(PUT_PARTIAL_DATA_A, 64'h0,  3, 8'h00, 64'hFFFFFFFFFFFFFFFF, ACCESS_ACK_D,      64'h0, 0);
    vt[22] = mk(GET_A,              64'h0,  3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h0, 0);
    vt[23] = mk(GET_A,              64'h7F, 0, 8'h80, 64'h0,                ACCESS_ACK_DATA_D, 64'hCC00000000000000, 0);
    vt[24] = mk(PUT_PARTIAL_DATA_A, 64'h1C, 2, 8'hF0, 64'h5566778899AABBCC, ACCESS_ACK_D,      64'h0, 0);
    vt[25] = mk(GET_A,              64'h18, 3, 8'hFF, 64'h0,                ACCESS_ACK_DATA_D, 64'h5566778800000000, 0);

    // Reset state while reset is held.
    #12;
    chk("rst_d_valid",  64'(d_valid),  64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_data",   d_data,        64'd0);
    chk("rst_d_error",  64'(d_error),  64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    chk("rst_d_size",   64'(d_size),   64'd0);
    chk("rst_d_sink",   64'(d_sink),   64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    // Vector table, issued back to back.
    for (int i = 0; i < 26; i++) begin
      send(vt[i].op, vt[i].addr, vt[i].size, vt[i].mask, vt[i].data, 3'(i),
           mkexp(vt[i].eop, vt[i].edata, vt[i].eerr, 3'(i), vt[i].size), w);
    end
    drain("vec_drain");

    // Streaming: one accept per cycle with d_ready held high.
    for (int i = 0; i < 8; i++) begin
      send(PUT_FULL_DATA_A, 64'(i * 8), 3, 8'hFF, sdata(i), 3'(i),
           mkexp(ACCESS_ACK_D, 64'h0, 0, 3'(i), 8'd3), w);
      chk("stream_put_wait", 64'(w), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      send(GET_A, 64'(i * 8), 3, 8'hFF, 64'h0, 3'(7 - i),
           mkexp(ACCESS_ACK_DATA_D, sdata(i), 0, 3'(7 - i), 8'd3), w);
      chk("stream_get_wait", 64'(w), 64'd0);
    end
    drain("stream_drain");

    // Backpressure: response held, queued request waits, then both move.
    d_ready = 1'b0;
    send(GET_A, 64'h8, 3, 8'hFF, 64'h0, 3'd6, mkexp(ACCESS_ACK_DATA_D, sdata(1), 0, 3'd6, 8'd3), w);
    a_valid = 1'b1; a_opcode = GET_A; a_address = 64'h0; a_size = 3; a_source = 3'd5;
    sb.push_back(mkexp(ACCESS_ACK_DATA_D, sdata(0), 0, 3'd5, 8'd3));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_d_valid", 64'(d_valid),  64'd1);
      chk("bp_a_ready", 64'(a_ready),  64'd0);
      chk("bp_d_data",  d_data,        sdata(1));
      chk("bp_d_src",   64'(d_source), 64'd6);
      chk("bp_d_op",    64'(d_opcode), 64'(ACCESS_ACK_DATA_D));
      chk("bp_d_err",   64'(d_error),  64'd0);
      @(posedge clk); #1;
    end
    d_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    drain("bp_drain");

    // Reset during a held response.
    d_ready = 1'b0;
    send(GET_A, 64'h10, 3, 8'hFF, 64'h0, 3'd2, mkexp(ACCESS_ACK_DATA_D, sdata(2), 0, 3'd2, 8'd3), w);
    @(negedge clk);
    chk("mid_d_valid_before", 64'(d_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_d_valid", 64'(d_valid), 64'd0);
    chk("mid_rst_d_data",  d_data,       64'd0);
    chk("mid_rst_a_ready", 64'(a_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    d_ready = 1'b1;
    send(GET_A, 64'h8, 3, 8'hFF, 64'h0, 3'd1, mkexp(ACCESS_ACK_DATA_D, 64'h0, 0, 3'd1, 8'd3), w);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
